mcdf_formatter: RTL and testbench
=================================

# mcdf_formatter

Packet formatter sitting directly downstream of the three per-channel 32-entry synchronous FIFOs in the MCDF datapath. It watches each FIFO's free-slot count and picks, round-robin, a channel holding at least one full packet. It then requests the output bus and, once granted, pops exactly one packet's worth of words from that FIFO. Words go out one per cycle with channel ID, length, start and end markers.

## Interface
- `NCH`, 3: number of channel FIFOs (fixed at 3; channel ID width 2).
- `DEPTH`, 32: FIFO depth; occupancy is `DEPTH - freeslot`.
- `clk_i`  in  1  single clock for the block.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `ch_en_i`  in  3  per-channel enable; a disabled channel is never selected.
- `pkt_len_i`  in  2  length code: 0→4, 1→8, 2→16, 3→32 words.
- `fifo_data_i`  in  3×32  FIFO head word per channel; combinational from the FIFO.
- `fifo_freeslot_i`  in  3×6  FIFO free-slot count per channel (0..32).
- `fifo_rd_o`  out  3  pop strobe per channel; at most one bit high.
- `fmt_req_o`  out  1  output-bus request.
- `fmt_grant_i`  in  1  output-bus grant.
- `fmt_chid_o`  out  2  channel of the current packet.
- `fmt_length_o`  out  6  word count of the current packet (4/8/16/32).
- `fmt_valid_o`  out  1  `fmt_data_o` holds a packet word this cycle.
- `fmt_data_o`  out  32  packet word.
- `fmt_start_o`  out  1  first word of packet.
- `fmt_end_o`  out  1  last word of packet.
- `fmt_parity_o`  out  1  even parity of `fmt_data_o` (see Configuration).
- `fmt_idle_o`  out  1  FSM is in IDLE.

## Operation
- Eligibility: channel i is eligible when `ch_en_i[i]` is high and `DEPTH - fifo_freeslot_i[i]` ≥ the decoded length. Compare in 6 bits.
- Round-robin: search starts at the channel after `last_ch`. `last_ch` resets to 2, so ch0 wins the first tie. `last_ch` updates when the FSM enters SEND.
- FSM has three states: IDLE, REQ, SEND.
- IDLE → REQ when any channel is eligible.
  - On this transition, latch the chosen channel into `fmt_chid_o`.
  - Latch the decoded length into `fmt_length_o`.
  - Changes on `pkt_len_i` or `ch_en_i` after the latch do not affect the packet in flight.
- REQ: `fmt_req_o` = 1 and is held until grant. REQ → SEND on `fmt_grant_i` = 1. Eligibility is not rechecked, because only this block drains the FIFOs.
- SEND: `fifo_rd_o[chid]` = 1 every cycle and `cnt` increments from 0.
  - SEND → IDLE in the cycle where `cnt == length-1`.
  - `cnt` is 6 bits and clears on entry to SEND.
- Output register: a word popped in cycle t appears in cycle t+1.
  - `fmt_valid_o` = 1 and `fmt_data_o` = the word registered at the pop.
  - `fmt_start_o` marks pop index 0; `fmt_end_o` marks pop index length-1.
- `fmt_grant_i` is ignored outside REQ.
- `fifo_rd_o` is combinational from state and the latched chid. It is never high outside SEND.

## Timing
- Reset values: state IDLE; `fifo_rd_o`, `fmt_req_o`, `fmt_valid_o`, `fmt_start_o`, `fmt_end_o`, `fmt_parity_o` = 0; `fmt_data_o` = 0; `fmt_chid_o` = 0; `fmt_length_o` = 0; `fmt_idle_o` = 1; `last_ch` = 2.
- Reset mid-packet aborts immediately. Words already popped are lost; there is no recovery.
- Latency from eligible to `fmt_req_o`: 1 cycle.
- Latency from grant to first pop: 1 cycle. First `fmt_valid_o` follows 1 cycle after that.
- A packet occupies SEND for exactly `length` cycles. `fmt_valid_o` is a contiguous burst of `length` cycles.
- Back-to-back packets:
  - IDLE may re-enter REQ in the cycle the last word is output.
  - There is a minimum 1-cycle IDLE gap between SEND periods.
  - Minimum 2 non-valid cycles between bursts when grant is immediate.
- Boundary cases:
  - A full FIFO (freeslot 0) with length 32 is eligible.
  - Occupancy exactly equal to length is eligible; length-1 is not.
  - Simultaneous FIFO writes during SEND do not alter the pop count.

## Configuration
- `MCDF_FMT_PARITY_EN` defined: `fmt_parity_o` = XOR-reduce of the popped word, registered alongside `fmt_data_o`. It is 0 whenever `fmt_valid_o` = 0.
- `MCDF_FMT_PARITY_EN` undefined: `fmt_parity_o` is tied 0. The port list does not change.

## Structure
- `mcdf_pkg` holds:
  - FSM state enum (IDLE/REQ/SEND);
  - constants `MCDF_NCH` = 3 and `MCDF_DEPTH` = 32;
  - function `len_decode(2-bit) → 6-bit`.
- Sub-module `mcdf_rr_arbiter`: 3-bit eligible vector plus `last_ch` → one-hot grant and 2-bit index. It is purely combinational.

## Test plan
- Reset, then ch0 at occupancy 4 with `pkt_len` 0, grant 1 cycle after req → 4 pops on ch0; `fmt_valid_o` for 4 cycles; start on word 1, end on word 4; chid 0; length 4.
- All three channels at occupancy 8 with `pkt_len` 1 → packets served in order ch0, ch1, ch2, ch0…; each packet is 8 words; exactly one `fifo_rd_o` bit is high.
- ch1 at occupancy 15 with `pkt_len` 2 → no request; after one more write (16) → req asserted the next cycle.
- Grant withheld for 20 cycles → `fmt_req_o` stays high and no pops occur. Change `pkt_len_i` from 0 to 3 mid-wait → packet is still 4 words.
- Full FIFO (freeslot 0) with `pkt_len` 3 → 32 pops; freeslot returns to 32; end marker on word 32. Pulse `rst_n_i` low at word 10 → all outputs return to 0 asynchronously and state is IDLE.
- With `MCDF_FMT_PARITY_EN`: word 0x0000_0007 → parity 1; word 0x0000_0003 → parity 0. Without the macro → parity is always 0.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared types, constants and the length-code decoder for the MCDF packet formatter.
package mcdf_pkg;

   localparam int unsigned MCDF_NCH   = 3;
   localparam int unsigned MCDF_DEPTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StSend
   } fmt_state_e;

   // Length code 0..3 maps to 4, 8, 16, 32 words.
   function automatic logic [5:0] len_decode(input logic [1:0] code);
      return 6'd4 << code;
   endfunction

endpackage

// File: rtl/mcdf_rr_arbiter.sv
// Combinational round-robin pick among eligible channels, starting after last_ch_i.
module mcdf_rr_arbiter
   import mcdf_pkg::*;
(
   input  logic [MCDF_NCH-1:0] elig_i,
   input  logic [1:0]          last_ch_i,
   output logic [MCDF_NCH-1:0] gnt_o,
   output logic [1:0]          idx_o
);

   always_comb begin
      logic found;
      int   cand;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 1; k <= int'(MCDF_NCH); k++) begin
         cand = (int'(last_ch_i) + k) % int'(MCDF_NCH);
         if (!found && elig_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = 2'(cand);
         end
      end
   end

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF packet formatter: picks a channel holding a full packet, requests the bus, pops it out.
// Optional even-parity output is enabled by defining MCDF_FMT_PARITY_EN.
module mcdf_formatter
   import mcdf_pkg::*;
#(
   parameter int unsigned NCH   = MCDF_NCH,
   parameter int unsigned DEPTH = MCDF_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NCH-1:0]        ch_en_i,
   input  logic [1:0]            pkt_len_i,
   input  logic [NCH-1:0][31:0]  fifo_data_i,
   input  logic [NCH-1:0][5:0]   fifo_freeslot_i,
   output logic [NCH-1:0]        fifo_rd_o,
   output logic                  fmt_req_o,
   input  logic                  fmt_grant_i,
   output logic [1:0]            fmt_chid_o,
   output logic [5:0]            fmt_length_o,
   output logic                  fmt_valid_o,
   output logic [31:0]           fmt_data_o,
   output logic                  fmt_start_o,
   output logic                  fmt_end_o,
   output logic                  fmt_parity_o,
   output logic                  fmt_idle_o
);

   fmt_state_e     state_q;
   logic           req_q;
   logic [1:0]     chid_q;
   logic [1:0]     last_ch_q;
   logic [5:0]     len_q;
   logic [5:0]     cnt_q;
   logic           valid_q;
   logic [31:0]    data_q;
   logic           start_q;
   logic           end_q;
`ifdef MCDF_FMT_PARITY_EN
   logic           par_q;
`endif

   logic [5:0]     cur_len;
   logic [NCH-1:0] elig;
   logic [NCH-1:0] arb_gnt;
   logic [1:0]     arb_idx;
   logic [31:0]    pop_word;

   assign cur_len  = len_decode(pkt_len_i);
   assign pop_word = fifo_data_i[chid_q];

   // Occupancy is derived from the free-slot count; 32 - 0 still fits in 6 bits.
   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         elig[i] = ch_en_i[i] && ((6'(DEPTH) - fifo_freeslot_i[i]) >= cur_len);
      end
   end

   mcdf_rr_arbiter u_arb (
      .elig_i    (elig),
      .last_ch_i (last_ch_q),
      .gnt_o     (arb_gnt),
      .idx_o     (arb_idx)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         chid_q    <= 2'd0;
         last_ch_q <= 2'd2;
         len_q     <= 6'd0;
         cnt_q     <= 6'd0;
         valid_q   <= 1'b0;
         data_q    <= 32'd0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
`ifdef MCDF_FMT_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
`ifdef MCDF_FMT_PARITY_EN
         par_q   <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (|arb_gnt) begin
                  state_q <= StReq;
                  req_q   <= 1'b1;
                  chid_q  <= arb_idx;
                  len_q   <= cur_len;
               end
            end
            StReq: begin
               if (fmt_grant_i) begin
                  state_q   <= StSend;
                  req_q     <= 1'b0;
                  cnt_q     <= 6'd0;
                  last_ch_q <= chid_q;
               end
            end
            StSend: begin
               valid_q <= 1'b1;
               data_q  <= pop_word;
               start_q <= (cnt_q == 6'd0);
               end_q   <= (cnt_q == len_q - 6'd1);
`ifdef MCDF_FMT_PARITY_EN
               par_q   <= ^pop_word;
`endif
               cnt_q   <= cnt_q + 6'd1;
               if (cnt_q == len_q - 6'd1) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      fifo_rd_o = '0;
      if (state_q == StSend) begin
         fifo_rd_o[chid_q] = 1'b1;
      end
   end

   assign fmt_req_o    = req_q;
   assign fmt_chid_o   = chid_q;
   assign fmt_length_o = len_q;
   assign fmt_valid_o  = valid_q;
   assign fmt_data_o   = data_q;
   assign fmt_start_o  = start_q;
   assign fmt_end_o    = end_q;
   assign fmt_idle_o   = (state_q == StIdle);
`ifdef MCDF_FMT_PARITY_EN
   assign fmt_parity_o = par_q;
`else
   assign fmt_parity_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcdf_formatter.sv
// Directed bench for mcdf_formatter with a behavioural model of the three upstream FIFOs.
module tb_mcdf_formatter;
   import mcdf_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       ch_en;
   logic [1:0]       pkt_len;
   logic [2:0][31:0] fifo_data;
   logic [2:0][5:0]  fifo_free;
   logic [2:0]       fifo_rd;
   logic             fmt_req;
   logic             fmt_grant;
   logic [1:0]       fmt_chid;
   logic [5:0]       fmt_length;
   logic             fmt_valid;
   logic [31:0]      fmt_data;
   logic             fmt_start;
   logic             fmt_end;
   logic             fmt_parity;
   logic             fmt_idle;

   int checks = 0;
   int errors = 0;
   int mid_push = 0;
   int n;

   logic [31:0] mem [3][32];
   int          wr_ptr [3] = '{0, 0, 0};
   int          rd_ptr [3] = '{0, 0, 0};
   logic [31:0] exp_q [3][$];

   always #5 clk = ~clk;

   mcdf_formatter dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .ch_en_i         (ch_en),
      .pkt_len_i       (pkt_len),
      .fifo_data_i     (fifo_data),
      .fifo_freeslot_i (fifo_free),
      .fifo_rd_o       (fifo_rd),
      .fmt_req_o       (fmt_req),
      .fmt_grant_i     (fmt_grant),
      .fmt_chid_o      (fmt_chid),
      .fmt_length_o    (fmt_length),
      .fmt_valid_o     (fmt_valid),
      .fmt_data_o      (fmt_data),
      .fmt_start_o     (fmt_start),
      .fmt_end_o       (fmt_end),
      .fmt_parity_o    (fmt_parity),
      .fmt_idle_o      (fmt_idle)
   );

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         fifo_data[c] = mem[c][rd_ptr[c] % 32];
         fifo_free[c] = 6'(32 - (wr_ptr[c] - rd_ptr[c]));
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (fifo_rd[c]) rd_ptr[c] <= rd_ptr[c] + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input int c, input logic [31:0] w);
      mem[c][wr_ptr[c] % 32] = w;
      wr_ptr[c] = wr_ptr[c] + 1;
      exp_q[c].push_back(w);
   endtask

   task automatic flush();
      for (int c = 0; c < 3; c++) begin
         wr_ptr[c] = rd_ptr[c];
         exp_q[c].delete();
      end
   endtask

   task automatic wait_req(input int max, output int cyc);
      cyc = 0;
      while (!fmt_req && cyc < max) begin
         step();
         cyc++;
      end
      chk("req_wait", 32'(fmt_req), 32'd1);
   endtask

   function automatic logic exp_par(input logic [31:0] w);
`ifdef MCDF_FMT_PARITY_EN
      return ^w;
`else
      return 1'b0;
`endif
   endfunction

   // Grant the pending request and check every popped word; abort_at > 0 resets after that word.
   task automatic serve(input int ch, input int lenw, input int abort_at);
      logic [31:0] w;
      chk("chid", 32'(fmt_chid), 32'(ch));
      chk("length", 32'(fmt_length), 32'(lenw));
      fmt_grant = 1'b1;
      step();
      fmt_grant = 1'b0;
      chk("rd_first", 32'(fifo_rd), 32'(1 << ch));
      chk("req_drop", 32'(fmt_req), 32'd0);
      chk("valid_pre", 32'(fmt_valid), 32'd0);
      for (int i = 0; i < lenw; i++) begin
         if (i == 5) begin
            for (int k = 0; k < mid_push; k++) push(ch, 32'hEE00_0000 + 32'(k));
         end
         step();
         w = (exp_q[ch].size() > 0) ? exp_q[ch].pop_front() : 32'hDEAD_DEAD;
         chk("valid", 32'(fmt_valid), 32'd1);
         chk("data", fmt_data, w);
         chk("start", 32'(fmt_start), 32'(i == 0));
         chk("end", 32'(fmt_end), 32'(i == lenw - 1));
         chk("parity", 32'(fmt_parity), 32'(exp_par(w)));
         if (abort_at == i + 1) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_rd", 32'(fifo_rd), 32'd0);
            chk("abort_req", 32'(fmt_req), 32'd0);
            chk("abort_valid", 32'(fmt_valid), 32'd0);
            chk("abort_flags", {29'd0, fmt_start, fmt_end, fmt_parity}, 32'd0);
            chk("abort_data", fmt_data, 32'd0);
            chk("abort_chid_len", {24'd0, fmt_chid, fmt_length}, 32'd0);
            chk("abort_idle", 32'(fmt_idle), 32'd1);
            step();
            rst_n = 1'b1;
            flush();
            return;
         end
         if (i < lenw - 1) chk("rd_onehot", 32'(fifo_rd), 32'(1 << ch));
      end
      chk("rd_after", 32'(fifo_rd), 32'd0);
      chk("idle_after", 32'(fmt_idle), 32'd1);
      step();
      chk("valid_gap", 32'(fmt_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      ch_en     = 3'b000;
      pkt_len   = 2'd0;
      fmt_grant = 1'b0;
      repeat (2) step();
      chk("rst_idle", 32'(fmt_idle), 32'd1);
      chk("rst_req", 32'(fmt_req), 32'd0);
      chk("rst_rd", 32'(fifo_rd), 32'd0);
      chk("rst_valid", 32'(fmt_valid), 32'd0);
      chk("rst_flags", {29'd0, fmt_start, fmt_end, fmt_parity}, 32'd0);
      chk("rst_data", fmt_data, 32'd0);
      chk("rst_chid_len", {24'd0, fmt_chid, fmt_length}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single 4-word packet on ch0, includes the parity words 7 and 3.
      ch_en   = 3'b001;
      pkt_len = 2'd0;
      push(0, 32'h0000_0007);
      push(0, 32'h0000_0003);
      push(0, 32'h8000_0001);
      push(0, 32'hA5A5_0004);
      step();
      chk("t1_req_latency", 32'(fmt_req), 32'd1);
      serve(0, 4, 0);

      // Fresh reset so last_ch is 2, then round-robin over three loaded channels.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      ch_en   = 3'b111;
      pkt_len = 2'd1;
      for (int i = 0; i < 16; i++) push(0, 32'h0000_0100 + 32'(i));
      for (int i = 0; i < 8; i++) push(1, 32'h0001_0100 + 32'(i));
      for (int i = 0; i < 8; i++) push(2, 32'h0002_0100 + 32'(i));
      wait_req(4, n);
      chk("t2_req_latency", 32'(n), 32'd1);
      serve(0, 8, 0);
      wait_req(4, n);
      chk("t2_gap_ch1", 32'(n), 32'd0);
      serve(1, 8, 0);
      wait_req(4, n);
      chk("t2_gap_ch2", 32'(n), 32'd0);
      serve(2, 8, 0);
      wait_req(4, n);
      chk("t2_gap_ch0", 32'(n), 32'd0);
      serve(0, 8, 0);
      repeat (3) step();
      chk("t2_drained", 32'(fmt_req), 32'd0);

      // Occupancy one short of the length is not eligible; exact length is.
      ch_en   = 3'b010;
      pkt_len = 2'd2;
      for (int i = 0; i < 15; i++) push(1, 32'h0003_0000 + 32'(i));
      repeat (5) step();
      chk("t3_no_req", 32'(fmt_req), 32'd0);
      chk("t3_idle", 32'(fmt_idle), 32'd1);
      push(1, 32'h0003_000F);
      step();
      chk("t3_req_latency", 32'(fmt_req), 32'd1);
      mid_push = 4;
      serve(1, 16, 0);
      mid_push = 0;
      chk("t3_free_after", 32'(fifo_free[1]), 32'd28);

      // Grant withheld; a length change mid-wait does not affect the latched packet.
      ch_en   = 3'b001;
      pkt_len = 2'd0;
      for (int i = 0; i < 4; i++) push(0, 32'h0004_0000 + 32'(i));
      wait_req(4, n);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t4_req_hold", 32'(fmt_req), 32'd1);
         chk("t4_no_pop", 32'(fifo_rd), 32'd0);
         if (k == 10) pkt_len = 2'd3;
      end
      serve(0, 4, 0);

      // Full FIFO with length 32, then a second packet aborted by reset after word 10.
      pkt_len = 2'd3;
      for (int i = 0; i < 32; i++) push(0, 32'h0005_0000 + 32'(i));
      wait_req(4, n);
      chk("t5_req_latency", 32'(n), 32'd1);
      serve(0, 32, 0);
      chk("t5_free_restored", 32'(fifo_free[0]), 32'd32);
      for (int i = 0; i < 32; i++) push(0, 32'h0006_0000 + 32'(i));
      wait_req(4, n);
      serve(0, 32, 10);
      repeat (2) step();
      chk("t5_post_idle", 32'(fmt_idle), 32'd1);
      chk("t5_post_req", 32'(fmt_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
